// File: rtl/framebuffer_reader.sv
// Wishbone burst reader that refills a show-ahead pixel FIFO and streams RGB pixels with start-of-frame.
// Optional macro FBR_UNDERFLOW_CNT_EN adds underflow_cnt_o, a saturating consumer-starvation counter.

// Show-ahead single-clock FIFO: head is combinational from the read pointer, clr empties it in one cycle.
module fbr_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

module framebuffer_reader #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] wshb_adr_o,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [3:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic [31:0] wshb_dat_i,
  input  logic        wshb_ack_i,
  input  logic        frame_restart_i,
`ifdef FBR_UNDERFLOW_CNT_EN
  output logic [15:0] underflow_cnt_o,
`endif
  output logic [23:0] pix_data_o,
  output logic        pix_sof_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i
);
  localparam int TOTAL = HDISP * VDISP;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int BW    = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              launch;
  logic              flush;
  logic              stb_q;
  logic [2:0]        cti_q;
  logic [31:0]       adr_q;
  logic [IDX_W-1:0]  pix_idx;
  logic [BW-1:0]     beats_left;
  logic              restart_pend;
  logic [31:0]       remain;
  logic [BW-1:0]     first_beats;
  logic              beat;
  logic              last_beat;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [24:0]       fifo_head;
  logic              fifo_pop;
  logic              unused_hi;

  assign remain      = 32'(TOTAL) - 32'(pix_idx);
  // Bursts are clipped so a burst never runs past the last pixel of the frame.
  assign first_beats = (remain < 32'(BURST_LEN)) ? remain[BW-1:0] : BW'(BURST_LEN);
  assign beat        = (state == BURST) && wshb_ack_i;
  assign last_beat   = beat && (beats_left == BW'(1));

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (restart_pend) begin
          state_nxt = FLUSH;
        end else if (!frame_restart_i &&
                     (fifo_count <= CW'(FIFO_DEPTH - BURST_LEN))) begin
          state_nxt = BURST;
          launch    = 1'b1;
        end
      end
      BURST: begin
        if (last_beat) state_nxt = IDLE;
      end
      FLUSH: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stb_q        <= 1'b0;
      cti_q        <= 3'b000;
      adr_q        <= BASE_ADR;
      pix_idx      <= '0;
      beats_left   <= '0;
      restart_pend <= 1'b0;
    end else begin
      state <= state_nxt;

      // A pulse landing on the FLUSH cycle stays pending so it is never lost.
      if (frame_restart_i)  restart_pend <= 1'b1;
      else if (flush)       restart_pend <= 1'b0;

      if (flush) begin
        pix_idx <= '0;
        adr_q   <= BASE_ADR;
      end else if (beat) begin
        if (pix_idx == IDX_W'(TOTAL - 1)) begin
          pix_idx <= '0;
          adr_q   <= BASE_ADR;
        end else begin
          pix_idx <= pix_idx + IDX_W'(1);
          adr_q   <= adr_q + 32'd4;
        end
      end

      if (launch) begin
        stb_q      <= 1'b1;
        beats_left <= first_beats;
        cti_q      <= (first_beats == BW'(1)) ? 3'b111 : 3'b010;
      end else if (beat) begin
        beats_left <= beats_left - BW'(1);
        if (last_beat) begin
          stb_q <= 1'b0;
          cti_q <= 3'b000;
        end else begin
          cti_q <= (beats_left == BW'(2)) ? 3'b111 : 3'b010;
        end
      end
    end
  end

  fbr_fifo #(.W(25), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (beat),
    .push_dat ({(pix_idx == '0), wshb_dat_i[23:0]}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Pixels are withheld while a restart is pending: they belong to the abandoned frame.
  assign pix_valid_o = !fifo_empty && !restart_pend;
  assign pix_data_o  = pix_valid_o ? fifo_head[23:0] : 24'h0;
  assign pix_sof_o   = pix_valid_o && fifo_head[24];
  assign fifo_pop    = pix_valid_o && pix_ready_i;

  assign wshb_adr_o = adr_q;
  assign wshb_cyc_o = stb_q;
  assign wshb_stb_o = stb_q;
  assign wshb_we_o  = 1'b0;
  assign wshb_sel_o = 4'hF;
  assign wshb_cti_o = cti_q;
  assign wshb_bte_o = 2'b00;
  assign unused_hi  = &{1'b0, wshb_dat_i[31:24]};

`ifdef FBR_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt_o <= 16'h0;
    end else if (flush) begin
      underflow_cnt_o <= 16'h0;
    end else if (pix_ready_i && !pix_valid_o && !restart_pend &&
                 (underflow_cnt_o != 16'hFFFF)) begin
      underflow_cnt_o <= underflow_cnt_o + 16'h1;
    end
  end
`endif
endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomised bench for framebuffer_reader against a queue-based model of the pixel stream.
module tb_framebuffer_reader;
  localparam int          HD    = 20;
  localparam int          VD    = 15;
  localparam int          TOTAL = HD * VD;
  localparam int          BL    = 64;
  localparam int          FD    = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] wshb_adr;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic [31:0] wshb_dat = 32'h0;
  logic        wshb_ack = 1'b0;
  logic        frame_restart = 1'b0;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid;
  logic        pix_ready = 1'b0;
`ifdef FBR_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  always #5 clk = ~clk;

  framebuffer_reader #(
    .HDISP(HD), .VDISP(VD), .BASE_ADR(BASE), .BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wshb_adr_o      (wshb_adr),
    .wshb_cyc_o      (wshb_cyc),
    .wshb_stb_o      (wshb_stb),
    .wshb_we_o       (wshb_we),
    .wshb_sel_o      (wshb_sel),
    .wshb_cti_o      (wshb_cti),
    .wshb_bte_o      (wshb_bte),
    .wshb_dat_i      (wshb_dat),
    .wshb_ack_i      (wshb_ack),
    .frame_restart_i (frame_restart),
`ifdef FBR_UNDERFLOW_CNT_EN
    .underflow_cnt_o (underflow_cnt),
`endif
    .pix_data_o      (pix_data),
    .pix_sof_o       (pix_sof),
    .pix_valid_o     (pix_valid),
    .pix_ready_i     (pix_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pixel index of the next beat, pending restart, expected FIFO contents.
  int          idx, beats_left, burst_beats, n_bursts, pops, sof_pops;
  bit          pend, in_burst, prev_stb, prev_pend, prev_rst;
  int          prev_qsize;
  logic [24:0] q[$];
  int          burst_len_log[$];
  logic [31:0] first_adr_log[$];
  int          ack_pct, rdy_pct, rst_ppm;
  bit          restart_req, lit_first, watch_flush, flush_pop_seen;
  logic [24:0] first_pix, flush_pix;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit          exp_valid, beat, pop, rst_now;
    logic [31:0] mw;
    logic [24:0] pix;
    @(negedge clk);
    if (wshb_stb && !in_burst) begin
      chk("idle_gap", {31'd0, prev_stb}, 32'd0);
      if (pend) begin
        q.delete();
        idx = 0;
        pend = 1'b0;
        watch_flush = 1'b1;
      end else begin
        chk("launch_occ", {31'd0, (prev_qsize <= FD - BL)}, 32'd1);
      end
      beats_left  = (TOTAL - idx < BL) ? TOTAL - idx : BL;
      in_burst    = 1'b1;
      burst_beats = 0;
      n_bursts++;
      first_adr_log.push_back(BASE + 32'(4 * idx));
    end else if (!prev_stb && !prev_pend && !prev_rst && prev_qsize <= FD - BL) begin
      chk("launch_late", {31'd0, wshb_stb}, 32'd1);
    end
    chk("bus_const", {24'd0, wshb_cyc ^ wshb_stb, wshb_we, wshb_sel, wshb_bte},
        {24'd0, 1'b0, 1'b0, 4'hF, 2'b00});
    if (in_burst) begin
      chk("stb_held", {31'd0, wshb_stb}, 32'd1);
      chk("adr", wshb_adr, BASE + 32'(4 * idx));
      chk("cti", {29'd0, wshb_cti}, (beats_left == 1) ? 32'd7 : 32'd2);
    end
    exp_valid = (q.size() != 0) && !pend;
    chk("valid", {31'd0, pix_valid}, {31'd0, exp_valid});
    if (exp_valid) chk("pixel", {7'd0, pix_sof, pix_data}, {7'd0, q[0]});
    chk("no_overflow", {31'd0, (q.size() <= FD)}, 32'd1);

    prev_stb   = wshb_stb;
    prev_qsize = q.size();
    prev_pend  = pend;

    wshb_ack  = ($urandom_range(99, 0) < ack_pct);
    pix_ready = ($urandom_range(99, 0) < rdy_pct);
    rst_now   = restart_req || ($urandom_range(999, 0) < rst_ppm);
    restart_req   = 1'b0;
    frame_restart = rst_now;
    prev_rst      = rst_now;
    mw = mem_word(wshb_adr);
    wshb_dat = {8'($urandom), mw[23:0]};

    pop  = exp_valid && pix_ready;
    beat = wshb_stb && wshb_ack;
    if (pop) begin
      pix = q.pop_front();
      if (pops == 0) first_pix = pix;
      pops++;
      if (pix[24]) sof_pops++;
      if (watch_flush) begin
        flush_pix = pix;
        flush_pop_seen = 1'b1;
        watch_flush = 1'b0;
      end
    end
    if (beat) begin
      if (lit_first && n_bursts == 1 && burst_beats == 0) begin
        chk("lit_adr0", wshb_adr, 32'h0000_1000);
        chk("lit_cti0", {29'd0, wshb_cti}, 32'd2);
      end
      if (lit_first && n_bursts == 1 && burst_beats == 63) begin
        chk("lit_adr63", wshb_adr, 32'h0000_10FC);
        chk("lit_cti63", {29'd0, wshb_cti}, 32'd7);
      end
      mw = mem_word(BASE + 32'(4 * idx));
      q.push_back({(idx == 0), mw[23:0]});
      idx = (idx + 1) % TOTAL;
      beats_left--;
      burst_beats++;
      if (beats_left == 0) begin
        in_burst = 1'b0;
        burst_len_log.push_back(burst_beats);
      end
    end
    if (rst_now) pend = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bus", {26'd0, wshb_stb, wshb_cyc, 1'b0, wshb_cti}, 32'd0);
    chk("rst_adr", wshb_adr, BASE);
    chk("rst_pix", {6'd0, pix_valid, pix_sof, pix_data}, 32'd0);
    wshb_ack = 1'b0;
    pix_ready = 1'b0;
    frame_restart = 1'b0;
    idx = 0; beats_left = 0; burst_beats = 0; n_bursts = 0; pops = 0; sof_pops = 0;
    pend = 1'b0; in_burst = 1'b0; prev_stb = 1'b0; prev_pend = 1'b0; prev_rst = 1'b0;
    prev_qsize = 0; restart_req = 1'b0; watch_flush = 1'b0; flush_pop_seen = 1'b0;
    q.delete(); burst_len_log.delete(); first_adr_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int nb;
    rst_ppm = 0;

    // Streaming with ack and ready always high, across two frame wraps.
    do_reset();
    ack_pct = 100; rdy_pct = 100; lit_first = 1'b1;
    for (int i = 0; i < 800; i++) step();
    lit_first = 1'b0;
    chk("first_pix", {7'd0, first_pix}, {7'd0, 25'h1_C10214});
    chk("burst0_len", 32'(burst_len_log[0]), 32'd64);
    chk("burst4_len", 32'(burst_len_log[4]), 32'd44);
    chk("burst5_len", 32'(burst_len_log[5]), 32'd64);
    chk("burst4_adr", first_adr_log[4], 32'h0000_1400);
    chk("wrap_adr", first_adr_log[5], 32'h0000_1000);
    chk("pops_range", {31'd0, (pops > 600 && pops <= 900)}, 32'd1);
    chk("sof_count", 32'(sof_pops), 32'd3);

    // Consumer stalled: the FIFO fills to exactly FIFO_DEPTH and the bus goes quiet.
    do_reset();
    ack_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 600; i++) step();
    chk("full_bursts", 32'(n_bursts), 32'd4);
    chk("full_occ", 32'(q.size()), 32'd256);
    chk("full_stb", {31'd0, wshb_stb}, 32'd0);
    chk("full_valid", {31'd0, pix_valid}, 32'd1);

    // Restart at beat 10 of the second burst.
    do_reset();
    ack_pct = 100; rdy_pct = 100;
    t = 0;
    while (!(in_burst && n_bursts == 2 && burst_beats == 10) && t < 2000) begin step(); t++; end
    chk("to_beat10", {31'd0, (t < 2000)}, 32'd1);
    restart_req = 1'b1;
    t = 0;
    while (first_adr_log.size() < 3 && t < 2000) begin step(); t++; end
    chk("to_post_restart", {31'd0, (t < 2000)}, 32'd1);
    chk("restart_burst_len", 32'(burst_len_log[1]), 32'd64);
    chk("restart_adr", first_adr_log[2], BASE);
    t = 0;
    while (!flush_pop_seen && t < 2000) begin step(); t++; end
    chk("restart_sof", {31'd0, flush_pop_seen & flush_pix[24]}, 32'd1);

    // Restart coinciding with the last-beat ack.
    t = 0;
    while (!(in_burst && beats_left == 1) && t < 2000) begin step(); t++; end
    chk("to_lastbeat", {31'd0, (t < 2000)}, 32'd1);
    restart_req = 1'b1;
    flush_pop_seen = 1'b0;
    nb = first_adr_log.size();
    t = 0;
    while (!flush_pop_seen && t < 2000) begin step(); t++; end
    chk("lastbeat_restart_seen", {31'd0, (first_adr_log.size() > nb)}, 32'd1);
    chk("lastbeat_restart_adr", first_adr_log[first_adr_log.size() - 1], BASE);
    chk("lastbeat_restart_sof", {31'd0, flush_pop_seen & flush_pix[24]}, 32'd1);

    // Random ack gaps, consumer stalls and occasional restarts.
    do_reset();
    ack_pct = 70; rdy_pct = 60; rst_ppm = 3;
    for (int i = 0; i < 4000; i++) step();
    rst_ppm = 0;
    chk("progress", {31'd0, (pops > 100)}, 32'd1);

`ifdef FBR_UNDERFLOW_CNT_EN
    do_reset();
    ack_pct = 0; rdy_pct = 100;
    for (int i = 0; i < 20; i++) step();
    chk("uf_count", {31'd0, (underflow_cnt >= 16'd19 && underflow_cnt <= 16'd21)}, 32'd1);
    ack_pct = 100; rdy_pct = 0;
    restart_req = 1'b1;
    nb = first_adr_log.size();
    t = 0;
    while (first_adr_log.size() <= nb && t < 2000) begin step(); t++; end
    chk("uf_to_flush", {31'd0, (t < 2000)}, 32'd1);
    chk("uf_cleared", {16'd0, underflow_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
